// File: rtl/session_manager_pkg.sv
// Session manager shared types.
// State, end-reason and button FSM encodings.
package session_manager_pkg;

  localparam int ID_W = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    LOGOUT    = 2'd2,
    WAIT_DROP = 2'd3
  } sm_state_t;

  typedef enum logic [1:0] {
    REASON_BTN   = 2'b00,
    REASON_IDLE  = 2'b01,
    REASON_GUEST = 2'b10,
    REASON_DROP  = 2'b11
  } reason_t;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_ON   = 2'd1,
    S_WAIT = 2'd2
  } btn_state_t;

endpackage

// File: rtl/session_manager_button_shaper.sv
// One registered pulse per button press.
// Re-arms only after the button is released.
module button_shaper (
  input  logic clk,
  input  logic rst,
  input  logic b_in,
  output logic b_out
);
  import session_manager_pkg::*;

  btn_state_t state;

  // press detect: pulse on the first high cycle, then wait for release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_OFF;
      b_out <= 1'b0;
    end else begin
      b_out <= 1'b0;
      unique case (state)
        S_OFF: begin
          if (b_in) begin
            state <= S_ON;
            b_out <= 1'b1;
          end
        end
        S_ON: begin
          state <= b_in ? S_WAIT : S_OFF;
        end
        S_WAIT: begin
          if (!b_in) state <= S_OFF;
        end
        default: state <= S_OFF;
      endcase
    end
  end

endmodule

// File: rtl/session_manager.sv
// Session manager: latches login identity, gates play,
// enforces idle and guest limits, issues logout requests.
module session_manager
  import session_manager_pkg::*;
#(
  parameter int TICK_CYCLES  = 50000000,
  parameter int GUEST_SECS   = 60,
  parameter int IDLE_SECS    = 30,
  parameter int PULSE_CYCLES = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            log_in_ctrl,
  input  logic            isGuest_ctrl,
  input  logic [ID_W-1:0] intID_ctrl,
  input  logic            logout_btn,
  input  logic            activity,
  output logic            log_out_ctrl,
  output logic            game_en,
  output logic [ID_W-1:0] cur_id,
  output logic            cur_guest,
  output logic [7:0]      secs_left,
  output logic [1:0]      end_reason
);

  localparam int TW =
    (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int PW =
    (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST =
    TW'(TICK_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LAST =
    PW'(PULSE_CYCLES - 1);
  localparam logic [7:0] GUEST_LOAD = 8'(GUEST_SECS);
  localparam logic [7:0] IDLE_LOAD  = 8'(IDLE_SECS);

  sm_state_t       state;
  logic [TW-1:0]   tick_cnt;
  logic [PW-1:0]   pulse_cnt;
  logic [7:0]      guest_left;
  logic [7:0]      idle_left;
  logic [1:0]      btn_sync;
  logic            btn_pulse;
  logic            tick;
  logic            guest_exp;
  logic            idle_exp;

  // bring the raw button into the clk domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) btn_sync <= 2'b00;
    else      btn_sync <= {btn_sync[0], logout_btn};
  end

  button_shaper u_shaper (
    .clk  (clk),
    .rst  (rst),
    .b_in (btn_sync[1]),
    .b_out(btn_pulse)
  );

  assign tick      = (tick_cnt == TICK_LAST);
  assign guest_exp = tick && cur_guest
                     && (guest_left == 8'd1);
  assign idle_exp  = tick && !activity
                     && (idle_left == 8'd1);
  assign secs_left = cur_guest ? guest_left : idle_left;

  // session FSM with registered outputs and countdowns
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      game_en      <= 1'b0;
      log_out_ctrl <= 1'b0;
      cur_id       <= '0;
      cur_guest    <= 1'b0;
      end_reason   <= 2'b00;
      tick_cnt     <= '0;
      pulse_cnt    <= '0;
      guest_left   <= 8'd0;
      idle_left    <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (log_in_ctrl) begin
            state      <= ACTIVE;
            game_en    <= 1'b1;
            cur_id     <= intID_ctrl;
            cur_guest  <= isGuest_ctrl;
            guest_left <= GUEST_LOAD;
            idle_left  <= IDLE_LOAD;
            tick_cnt   <= '0;
            end_reason <= 2'b00;
          end
        end
        ACTIVE: begin
          tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
          if (activity)  idle_left <= IDLE_LOAD;
          else if (tick) idle_left <= idle_left - 8'd1;
          if (tick && cur_guest)
            guest_left <= guest_left - 8'd1;
          priority case (1'b1)
            !log_in_ctrl: begin
              state      <= IDLE;
              game_en    <= 1'b0;
              end_reason <= REASON_DROP;
            end
            btn_pulse: begin
              state        <= LOGOUT;
              game_en      <= 1'b0;
              log_out_ctrl <= 1'b1;
              pulse_cnt    <= '0;
              end_reason   <= REASON_BTN;
            end
            guest_exp: begin
              state        <= LOGOUT;
              game_en      <= 1'b0;
              log_out_ctrl <= 1'b1;
              pulse_cnt    <= '0;
              end_reason   <= REASON_GUEST;
            end
            idle_exp: begin
              state        <= LOGOUT;
              game_en      <= 1'b0;
              log_out_ctrl <= 1'b1;
              pulse_cnt    <= '0;
              end_reason   <= REASON_IDLE;
            end
            default: ;
          endcase
        end
        LOGOUT: begin
          if (pulse_cnt == PULSE_LAST) begin
            state        <= WAIT_DROP;
            log_out_ctrl <= 1'b0;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        WAIT_DROP: begin
          if (!log_in_ctrl) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_session_manager.sv
// Scoreboarded random bench for session_manager.
// Session outcomes come from a per-second reference model.
module tb_session_manager;

  localparam int TICK    = 4;
  localparam int GUEST   = 3;
  localparam int IDL     = 5;
  localparam int PULSE   = 2;
  localparam int BTN_LAT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       log_in_ctrl = 1'b0;
  logic       isGuest_ctrl = 1'b0;
  logic [2:0] intID_ctrl = 3'd0;
  logic       logout_btn = 1'b0;
  logic       activity = 1'b0;
  logic       log_out_ctrl;
  logic       game_en;
  logic [2:0] cur_id;
  logic       cur_guest;
  logic [7:0] secs_left;
  logic [1:0] end_reason;

  session_manager #(
    .TICK_CYCLES (TICK),
    .GUEST_SECS  (GUEST),
    .IDLE_SECS   (IDL),
    .PULSE_CYCLES(PULSE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .log_in_ctrl (log_in_ctrl),
    .isGuest_ctrl(isGuest_ctrl),
    .intID_ctrl  (intID_ctrl),
    .logout_btn  (logout_btn),
    .activity    (activity),
    .log_out_ctrl(log_out_ctrl),
    .game_en     (game_en),
    .cur_id      (cur_id),
    .cur_guest   (cur_guest),
    .secs_left   (secs_left),
    .end_reason  (end_reason)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int           start;
    int           dur;
    logic [1:0]   reason;
    logic [2:0]   id;
    logic         guest;
    int           pulse;
    logic [255:0] act;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input int got,
                     input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               name, got, want, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Remaining seconds after relative edge e of a session.
  function automatic int exp_secs(input exp_t s, input int e);
    int a;
    a = 0;
    if (s.guest) return GUEST - e / TICK;
    for (int k = 1; k <= e; k++)
      if (s.act[k]) a = k;
    return IDL - (e / TICK - a / TICK);
  endfunction

  // Walk the session second by second; first exit rule wins.
  function automatic void model(
    input  logic         g,
    input  logic [255:0] act,
    input  int           bp,
    input  int           drop,
    output int           x,
    output logic [1:0]   r
  );
    int a;
    bit tk;
    a = 0;
    x = 0;
    r = 2'b00;
    for (int e = 1; e < 256; e++) begin
      tk = (e % TICK == 0);
      if (drop == e) begin
        x = e; r = 2'b11; return;
      end
      if (bp != 0 && bp + BTN_LAT == e) begin
        x = e; r = 2'b00; return;
      end
      if (tk && g && e / TICK == GUEST) begin
        x = e; r = 2'b10; return;
      end
      if (tk && !act[e] && (e / TICK - a / TICK) == IDL) begin
        x = e; r = 2'b01; return;
      end
      if (act[e]) a = e;
    end
  endfunction

  task automatic run_session(
    input logic [2:0]   id,
    input logic         g,
    input logic [255:0] act,
    input int           bp,
    input int           hold,
    input int           drop,
    input int           extra
  );
    int x;
    int end_r;
    int e;
    logic [1:0] r;
    exp_t s;
    model(g, act, bp, drop, x, r);
    intID_ctrl   = id;
    isGuest_ctrl = g;
    log_in_ctrl  = 1'b1;
    s.start  = cyc + 1;
    s.dur    = x;
    s.reason = r;
    s.id     = id;
    s.guest  = g;
    s.pulse  = (r == 2'b11) ? 0 : PULSE;
    s.act    = act;
    q.push_back(s);
    end_r = (r == 2'b11) ? x : x + PULSE;
    if (bp != 0 && bp + hold + BTN_LAT > end_r)
      end_r = bp + hold + BTN_LAT;
    step();
    for (int r0 = 0; r0 < end_r; r0++) begin
      e = r0 + 1;
      activity     = (e <= x) && act[e];
      logout_btn   = (bp != 0) && e > bp && e <= bp + hold;
      log_in_ctrl  = !(drop != 0 && e >= drop);
      intID_ctrl   = 3'($urandom);
      isGuest_ctrl = 1'($urandom);
      step();
    end
    activity   = 1'b0;
    logout_btn = 1'b0;
    repeat (extra) begin
      intID_ctrl = 3'($urandom);
      step();
    end
    log_in_ctrl = 1'b0;
    step();
    repeat (1 + $urandom % 3) step();
  endtask

  // monitor: pops one expectation per game_en session
  initial begin : mon
    bit   on;
    int   dur;
    int   pw;
    exp_t cur;
    on = 1'b0;
    dur = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        on = 1'b0;
        continue;
      end
      if (!on && game_en) begin
        on  = 1'b1;
        dur = 0;
        if (q.size() == 0) begin
          cur = '{default: 0};
          cur.start = -1;
        end else begin
          cur = q.pop_front();
        end
        chk("start_cycle", cyc, cur.start);
        chk("end_reason_clear", end_reason, 0);
      end
      if (on && game_en) begin
        dur++;
        chk("secs_left", secs_left, exp_secs(cur, dur - 1));
        chk("no_pulse_active", log_out_ctrl, 0);
      end else if (on && !game_en) begin
        on = 1'b0;
        chk("duration", dur, cur.dur);
        chk("end_reason", end_reason, cur.reason);
        chk("cur_id", cur_id, cur.id);
        chk("cur_guest", cur_guest, cur.guest);
        pw = 0;
        while (log_out_ctrl && pw < 20) begin
          pw++;
          @(negedge clk);
        end
        chk("pulse_width", pw, cur.pulse);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : drv
    logic [255:0] act;
    int mode;
    int bp;
    int drop;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_game_en", game_en, 0);
    chk("rst_log_out", log_out_ctrl, 0);
    chk("rst_cur_id", cur_id, 0);
    chk("rst_cur_guest", cur_guest, 0);
    chk("rst_secs_left", secs_left, 0);
    chk("rst_end_reason", end_reason, 0);
    rst = 1'b1;
    step();

    intID_ctrl   = 3'd5;
    isGuest_ctrl = 1'b1;
    log_in_ctrl  = 1'b1;
    repeat (4) step();
    chk("pre_rst_game_en", game_en, 1);
    chk("pre_rst_cur_id", cur_id, 5);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_game_en", game_en, 0);
    chk("mid_rst_cur_id", cur_id, 0);
    chk("mid_rst_cur_guest", cur_guest, 0);
    chk("mid_rst_log_out", log_out_ctrl, 0);
    repeat (3) step();
    chk("held_rst_game_en", game_en, 0);
    log_in_ctrl = 1'b0;
    rst = 1'b1;
    step();

    intID_ctrl   = 3'd6;
    isGuest_ctrl = 1'b0;
    log_in_ctrl  = 1'b1;
    step();
    logout_btn = 1'b1;
    for (int i = 0; i < 20 && !log_out_ctrl; i++) step();
    chk("logout_seen", log_out_ctrl, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_drops_log_out", log_out_ctrl, 0);
    chk("rst_clears_id", cur_id, 0);
    logout_btn  = 1'b0;
    log_in_ctrl = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    mon_en = 1'b1;

    act = '0;
    for (int k = 2; k < 250; k += 2) act[k] = 1'b1;
    run_session(3'd5, 1'b1, act, 0, 0, 0, 2);
    act = '0;
    run_session(3'd2, 1'b0, act, 0, 0, 0, 1);
    act[20] = 1'b1;
    run_session(3'd2, 1'b0, act, 0, 0, 0, 0);
    act = '0;
    run_session(3'd3, 1'b0, act, 3, 9, 0, 6);
    run_session(3'd1, 1'b0, act, 0, 0, 7, 0);
    run_session(3'd4, 1'b1, act, 0, 0, 13, 0);
    run_session(3'd7, 1'b0, act, 2, 1, 0, 8);
    run_session(3'd6, 1'b1, act, 0, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      act  = '0;
      mode = $urandom % 4;
      for (int k = 1; k < 180; k++) begin
        case (mode)
          1: act[k] = (k % 2 == 0);
          2: act[k] = ($urandom % 6 == 0);
          default: act[k] = 1'b0;
        endcase
      end
      if (mode == 3) act[1 + $urandom % 40] = 1'b1;
      bp   = ($urandom % 2 == 1) ? 1 + $urandom % 60 : 0;
      drop = ($urandom % 3 == 0) ? 1 + $urandom % 80 : 0;
      run_session(3'($urandom), 1'($urandom), act, bp,
                  1 + $urandom % 12, drop, $urandom % 6);
    end

    repeat (5) step();
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/session_manager.md
Name: session_manager

Overview:
- Downstream consumer of the Authentication stage. Sits between Authentication and the game logic.
- Latches the logged-in user identity and gates game play through game_en.
- Enforces an inactivity timeout and a guest time limit.
- Handles a physical logout push-button, and issues the log_out_ctrl request back to Authentication.

Parameters:
TICK_CYCLES, 50000000, clk cycles per one-second tick (simulation uses small values)
GUEST_SECS, 60, maximum guest session length in ticks (must be >=1)
IDLE_SECS, 30, inactivity limit in ticks (must be >=1)
PULSE_CYCLES, 9, cycles log_out_ctrl is held high per logout request (must be >=1)

Ports:
clk  in  1  50MHz system clock
rst  in  1  asynchronous active-low reset
log_in_ctrl  in  1  level from Authentication; high while a user is logged in
isGuest_ctrl  in  1  guest flag from Authentication; sampled on login
intID_ctrl  in  3  user index from Authentication; sampled on login
logout_btn  in  1  raw push-button, high while pressed
activity  in  1  one-cycle pulse from game logic on any user action
log_out_ctrl  out  1  logout request to Authentication
game_en  out  1  high only in ACTIVE
cur_id  out  3  latched user index
cur_guest  out  1  latched guest flag
secs_left  out  8  remaining guest seconds; equals IDLE countdown when not guest
end_reason  out  2  00 button, 01 idle, 10 guest limit, 11 external drop

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; all counters 0.
- State IDLE:
  - When log_in_ctrl=1, next cycle enter ACTIVE.
  - On that transition, latch cur_id and cur_guest from the inputs.
  - On that transition, load guest_left=GUEST_SECS, idle_left=IDLE_SECS and tick_cnt=0, and clear end_reason.
- State ACTIVE:
  - game_en=1.
  - tick_cnt counts 0..TICK_CYCLES-1 and wraps; a tick fires in the cycle where tick_cnt==TICK_CYCLES-1.
  - On a tick, idle_left decrements, and guest_left decrements if cur_guest.
  - activity reloads idle_left=IDLE_SECS. tick_cnt is not reset by activity.
  - If activity and a tick occur in the same cycle, the reload wins.
  - Exit conditions are evaluated each cycle, in priority order:
    1. log_in_ctrl=0 → IDLE, end_reason=11, no log_out_ctrl pulse.
    2. Shaped button pulse → LOGOUT, end_reason=00.
    3. Tick with cur_guest and guest_left==1 → LOGOUT, end_reason=10.
    4. Tick with idle_left==1 and no activity → LOGOUT, end_reason=01.
  - secs_left = guest_left if cur_guest, else idle_left.
- State LOGOUT:
  - game_en=0; log_out_ctrl=1 for exactly PULSE_CYCLES cycles, counted by pulse_cnt; then go to WAIT_DROP.
  - If log_in_ctrl falls during LOGOUT, finish the pulse anyway.
- State WAIT_DROP:
  - log_out_ctrl=0.
  - Stay until log_in_ctrl=0, then go to IDLE.
  - A new login cannot start until log_in_ctrl has been observed low.
- Button:
  - logout_btn passes through a 2-flop synchronizer, then button_shaper.
  - Exactly one 1-cycle pulse per press, regardless of press length.
  - The pulse is ignored outside ACTIVE.
- Latched values:
  - cur_id and cur_guest hold their values after logout until the next login.
  - end_reason holds until the next login.
- Reset mid-session: immediate return to IDLE with outputs 0; log_out_ctrl drops asynchronously.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=2'd0, ACTIVE=2'd1, LOGOUT=2'd2, WAIT_DROP=2'd3
  - end_reason codes: REASON_BTN, REASON_IDLE, REASON_GUEST, REASON_DROP
  - ID width constant: 3
- One sub-module: button_shaper (clk, rst, b_in, b_out).
  - 3-state FSM: S_OFF, S_ON, S_WAIT.
  - Emits one pulse per press and waits for release before re-arming.

Test Plan:
All scenarios use TICK_CYCLES=4, GUEST_SECS=3, IDLE_SECS=5, PULSE_CYCLES=2.
1. Reset low for 3 cycles during ACTIVE → game_en, log_out_ctrl, cur_id, cur_guest all 0 immediately; state IDLE.
2. Guest limit: login with isGuest=1, intID=5, activity every 2 cycles.
   - Required: game_en rises 1 cycle after log_in_ctrl; cur_id=5.
   - Required: log_out_ctrl high exactly 12 and 13 cycles after game_en rose; end_reason=10.
   - Then drop log_in_ctrl → IDLE.
3. Idle timeout: login with isGuest=0, intID=2, no activity.
   - Required: log_out_ctrl rises 20 cycles after game_en; end_reason=01; secs_left steps 5,4,3,2,1.
   - Variant: an activity pulse in a tick cycle → idle_left reloads to 5 and no logout.
4. Button: login as user 3, hold logout_btn for 9 cycles.
   - Required: exactly one LOGOUT entry; log_out_ctrl high 2 cycles; end_reason=00.
   - Required: stays in WAIT_DROP while log_in_ctrl=1.
5. External drop: log_in_ctrl falls while ACTIVE → IDLE next cycle, log_out_ctrl never asserted, end_reason=11.
6. Re-login guard: keep log_in_ctrl high after the LOGOUT pulse → no new ACTIVE until log_in_ctrl goes 0 then 1, after which cur_id updates to the new value.
